// File: rtl/ca_row_sink.sv
// Double-buffered sink for CA generation rows: captures a row on load/ack and
// streams it out as W-bit beats with line/frame markers while the next row is held.
module ca_row_sink #(
    parameter int ROW_W = 512,
    parameter int W     = 8,
    parameter int ROWS  = 480,
    localparam int BEATS = ROW_W / W,
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [ROW_W-1:0] ca_in,
    output logic             ack,
    output logic [W-1:0]     m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_sol,
    output logic             m_eol,
    output logic             m_sof,
    output logic [RW-1:0]    row_idx
);

    generate
        if ((ROW_W % W) != 0) begin : g_bad_width
            $error("ca_row_sink: ROW_W must be a multiple of W");
        end
    endgenerate

    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);

    logic [ROW_W-1:0] hold_reg;
    logic [ROW_W-1:0] shifter_reg;
    logic             hold_full_reg;
    logic             shift_full_reg;
    logic             armed_reg;
    logic             ack_reg;
    logic [BW-1:0]    beat_reg;
    logic [RW-1:0]    row_idx_reg;

    logic capture;
    logic handshake;
    logic last_beat;
    logic transfer;

    // Beat view of the shifter; the stream just indexes it by beat number.
    logic [W-1:0] beat_words [BEATS];
    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_words
            assign beat_words[gi] = shifter_reg[gi*W +: W];
        end
    endgenerate

    always_comb begin
        capture   = load & armed_reg & ~hold_full_reg;
        handshake = shift_full_reg & m_ready;
        last_beat = handshake & (beat_reg == LAST_BEAT);
        // Hold moves into the shifter when it is idle or draining its last beat.
        transfer  = hold_full_reg & (~shift_full_reg | last_beat);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ack_reg        <= 1'b0;
            hold_full_reg  <= 1'b0;
            shift_full_reg <= 1'b0;
            armed_reg      <= 1'b1;
            beat_reg       <= '0;
            row_idx_reg    <= '0;
        end else begin
            ack_reg <= capture;

            // A level load re-arms only after it has been seen low once.
            if (capture)
                armed_reg <= 1'b0;
            else if (!load)
                armed_reg <= 1'b1;

            if (capture)
                hold_full_reg <= 1'b1;
            else if (transfer)
                hold_full_reg <= 1'b0;

            if (handshake) begin
                if (last_beat) begin
                    row_idx_reg    <= (row_idx_reg == LAST_ROW) ? '0 : row_idx_reg + 1'b1;
                    shift_full_reg <= 1'b0;
                end else begin
                    beat_reg <= beat_reg + 1'b1;
                end
            end

            if (transfer) begin
                shift_full_reg <= 1'b1;
                beat_reg       <= '0;
            end
        end
    end

    // Row data paths carry no reset; their full flags qualify them.
    always_ff @(posedge clk) begin
        if (capture)
            hold_reg <= ca_in;
        if (transfer)
            shifter_reg <= hold_reg;
    end

    assign ack     = ack_reg;
    assign m_valid = shift_full_reg;
    assign m_data  = shift_full_reg ? beat_words[beat_reg] : '0;
    assign m_sol   = shift_full_reg & (beat_reg == '0);
    assign m_eol   = shift_full_reg & (beat_reg == LAST_BEAT);
    assign m_sof   = shift_full_reg & (beat_reg == '0) & (row_idx_reg == '0);
    assign row_idx = row_idx_reg;

endmodule

// File: tb/tb_ca_row_sink.sv
// Randomised bench for ca_row_sink: a row scoreboard predicts every beat, marker
// and row index; directed phases cover latency, back-pressure, re-arm and reset.
module tb_ca_row_sink;

    localparam int ROW_W = 512;
    localparam int W     = 8;
    localparam int ROWS  = 4;
    localparam int BEATS = ROW_W / W;
    localparam int RW    = 2;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             load;
    logic [ROW_W-1:0] ca_in;
    logic             ack;
    logic [W-1:0]     m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_sol;
    logic             m_eol;
    logic             m_sof;
    logic [RW-1:0]    row_idx;

    ca_row_sink #(.ROW_W(ROW_W), .W(W), .ROWS(ROWS)) dut (
        .clk(clk), .reset_n(reset_n), .load(load), .ca_in(ca_in), .ack(ack),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_sol(m_sol),
        .m_eol(m_eol), .m_sof(m_sof), .row_idx(row_idx)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: rows in ack order, beat position and row number.
    logic [ROW_W-1:0] exp_q [$];
    int eol_cyc_q [$];
    int k = 0, row_num = 0, rows_done = 0, ack_count = 0;
    logic prev_ack = 0, prev_load = 0, prev_stall = 0;
    logic [W-1:0] prev_data;
    logic prev_sol, prev_eol, prev_sof;
    logic rand_ready = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            k = 0; row_num = 0;
            prev_ack = 0; prev_load = 0; prev_stall = 0;
        end else begin
            if (ack) begin
                ack_count++;
                check("ack_width", prev_ack, 0);
                check("ack_without_load", prev_load, 1);
            end
            prev_ack  = ack;
            prev_load = load;
            if (prev_stall) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, prev_data);
                check("stall_markers", {m_sol, m_eol, m_sof}, {prev_sol, prev_eol, prev_sof});
            end
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", m_valid, 0);
                end else begin
                    logic [ROW_W-1:0] cur;
                    logic [W-1:0] e;
                    cur = exp_q[0];
                    e = cur[k*W +: W];
                    check("beat_data", m_data, e);
                    check("beat_sol", m_sol, k == 0);
                    check("beat_eol", m_eol, k == BEATS - 1);
                    check("beat_sof", m_sof, (k == 0) && (row_num == 0));
                    check("beat_row_idx", row_idx, row_num);
                    if (m_ready) begin
                        if (k == BEATS - 1) begin
                            void'(exp_q.pop_front());
                            k = 0;
                            row_num = (row_num + 1) % ROWS;
                            rows_done++;
                            eol_cyc_q.push_back(cyc);
                        end else begin
                            k++;
                        end
                    end
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_sol = m_sol; prev_eol = m_eol; prev_sof = m_sof;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            m_ready = ($urandom_range(0, 3) != 0);
        end
    end

    function automatic logic [ROW_W-1:0] rand_row();
        logic [ROW_W-1:0] r;
        for (int i = 0; i < ROW_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 0; load = 0; m_ready = 0;
        tick(); tick();
        reset_n = 1;
    endtask

    // Producer: hold load until ack, keep it high extra cycles, then drop for one edge.
    task automatic send_row(input logic [ROW_W-1:0] row, input int extra_hold, output int ack_cyc);
        int n = 0;
        ca_in = row;
        load  = 1;
        ack_cyc = -1;
        do begin
            tick();
            n++;
        end while (!ack && n < 3000);
        if (ack) begin
            exp_q.push_back(row);
            ack_cyc = cyc;
            repeat (extra_hold) tick();
        end else begin
            check("ack_timeout", ack, 1);
        end
        load = 0;
        tick();
    endtask

    task automatic wait_rows(input int target, input int budget);
        int n = 0;
        while (rows_done < target && n < budget) begin
            tick();
            n++;
        end
        check("rows_timeout", rows_done >= target, 1);
    endtask

    logic [ROW_W-1:0] r;
    int ca_a, ca_b, c1, c2, c3, c4, bub, base_ack, base_rows, n;

    initial begin
        ca_in = '0;
        do_reset();

        // Reset state
        check("rst_ack", ack, 0);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_sol", m_sol, 0);
        check("rst_eol", m_eol, 0);
        check("rst_sof", m_sof, 0);
        check("rst_row_idx", row_idx, 0);

        // Single row: ack at t+1, first beat at t+2, only beat 31 carries 8'h80
        m_ready = 1;
        r = '0; r[255] = 1'b1;
        ca_in = r; load = 1;
        tick();
        check("t1_ack_t1", ack, 1);
        check("t1_valid_t1", m_valid, 0);
        exp_q.push_back(r);
        load = 0;
        tick();
        check("t1_ack_t2", ack, 0);
        check("t1_valid_t2", m_valid, 1);
        check("t1_sof_t2", m_sof, 1);
        wait_rows(1, 200);

        // Back-to-back rows with m_ready high: no bubbles, B acked before A ends
        eol_cyc_q.delete();
        base_rows = rows_done;
        fork
            begin
                send_row(rand_row(), 0, ca_a);
                send_row(rand_row(), 0, ca_b);
            end
            begin
                n = 0;
                while (!m_valid && n < 50) begin tick(); n++; end
                bub = 0;
                repeat (2 * BEATS) begin
                    if (!m_valid) bub++;
                    tick();
                end
            end
        join
        wait_rows(base_rows + 2, 300);
        check("t2_bubbles", bub, 0);
        check("t2_ackB_before_eolA", (eol_cyc_q.size() > 0) && (ca_b < eol_cyc_q[0]), 1);

        // Back-pressure: three rows with m_ready low, only two acked
        do_reset();
        eol_cyc_q.delete();
        base_ack = ack_count;
        base_rows = rows_done;
        fork
            begin
                send_row(rand_row(), 0, c1);
                send_row(rand_row(), 0, c2);
                send_row(rand_row(), 0, c3);
            end
        join_none
        repeat (150) tick();
        check("t3_two_acks", ack_count - base_ack, 2);
        check("t3_load_pending", load, 1);
        m_ready = 1;
        wait_rows(base_rows + 3, 800);
        check("t3_third_ack_after_eol", (eol_cyc_q.size() > 0) && (c3 > eol_cyc_q[0]), 1);
        check("t3_three_acks", ack_count - base_ack, 3);

        // Load held high after ack: captured once only
        base_ack = ack_count;
        base_rows = rows_done;
        send_row(rand_row(), 20, c4);
        wait_rows(base_rows + 1, 300);
        repeat (10) tick();
        check("t4_one_ack", ack_count - base_ack, 1);
        check("t4_one_row", rows_done - base_rows, 1);

        // Nine rows under random stalls: row_idx wraps at ROWS, m_sof on rows 0,4,8
        do_reset();
        base_rows = rows_done;
        rand_ready = 1;
        for (int i = 0; i < 9; i++) send_row(rand_row(), $urandom_range(0, 3), c4);
        wait_rows(base_rows + 9, 3000);
        rand_ready = 0;
        tick();
        check("t5_row_idx_end", row_idx, 9 % ROWS);

        // Reset while beat 20 is on the output
        m_ready = 1;
        send_row(rand_row(), 0, c4);
        n = 0;
        while (k != 20 && n < 200) begin tick(); n++; end
        check("t6_reached_beat20", k, 20);
        reset_n = 0;
        tick();
        check("t6_rst_valid", m_valid, 0);
        check("t6_rst_data", m_data, 0);
        check("t6_rst_markers", {m_sol, m_eol, m_sof}, 3'b000);
        check("t6_rst_row_idx", row_idx, 0);
        reset_n = 1;
        tick();
        check("t6_no_partial", m_valid, 0);
        base_rows = rows_done;
        send_row(rand_row(), 0, c4);
        check("t6_restart_sof", m_sof, 1);
        wait_rows(base_rows + 1, 300);

        repeat (5) tick();
        check("leftover_rows", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
